// File: rtl/au_sat_pipe_pkg.sv
// Shared op encodings and saturation-limit helpers for the saturating add/sub unit.
// No latency: constants and constant functions only.
// No flow control: nothing in this package holds state.
package au_pkg;

    typedef enum logic [1:0] {
        AU_ADD  = 2'b00,
        AU_SUB  = 2'b01,
        AU_PADD = 2'b10,
        AU_PSUB = 2'b11
    } au_op_e;

    // Widest lane/word the limit helpers can describe; callers slice down to their width.
    localparam int SAT_MAX_W = 64;

    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
        return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
        return SAT_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/au_sat_pipe_lane.sv
// One lane of the adder: a + b + cin with raw carry and signed-overflow detect.
// Purely combinational, zero cycles.
// No flow control; the enclosing pipeline registers the outputs.
module au_lane #(
    parameter int LW = 8
) (
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    input  logic          cin,
    output logic [LW-1:0] sum,
    output logic          carry,
    output logic          ov
);

    logic [LW:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b} + {{LW{1'b0}}, cin};
    assign sum      = full_sum[LW-1:0];
    assign carry    = full_sum[LW];

    // b is already inverted for subtracts, so this is the plain same-sign-in / other-sign-out test.
    assign ov = (a[LW-1] == b[LW-1]) & (sum[LW-1] != a[LW-1]);

endmodule

// File: rtl/au_sat_pipe.sv
// Pipelined saturating ADD/SUB and packed PADD/PSUB with Z/V/N flags and raw carry.
// Latency 2 cycles (S1 raw sum, S2 saturated result), 1 op/cycle when not stalled.
// valid/ready: each stage advances only when the stage downstream is empty or draining.
module au_sat_pipe
    import au_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int LW = WIDTH / LANES;

    localparam logic [SAT_MAX_W-1:0] LANE_MAX_X = sat_max(LW);
    localparam logic [SAT_MAX_W-1:0] LANE_MIN_X = sat_min(LW);
    localparam logic [SAT_MAX_W-1:0] WORD_MAX_X = sat_max(WIDTH);
    localparam logic [SAT_MAX_W-1:0] WORD_MIN_X = sat_min(WIDTH);

    localparam logic [LW-1:0]    LANE_MAX = LANE_MAX_X[LW-1:0];
    localparam logic [LW-1:0]    LANE_MIN = LANE_MIN_X[LW-1:0];
    localparam logic [WIDTH-1:0] WORD_MAX = WORD_MAX_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] WORD_MIN = WORD_MIN_X[WIDTH-1:0];

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [LANES-1:0] ov;
        logic [LANES-1:0] a_msb;
        logic             packed_mode;
        logic             cout;
    } s1_t;

    au_op_e           op_e;
    logic             is_sub;
    logic             is_packed;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] lane_sum;
    logic [LANES-1:0] lane_ov;
    logic [LANES-1:0] lane_a_msb;

    s1_t              s1_d;
    s1_t              s1_q;
    logic             s1_valid;
    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH-1:0] sat_res;
    logic             any_ov;

    assign op_e      = au_op_e'(op);
    assign is_sub    = (op_e == AU_SUB)  || (op_e == AU_PSUB);
    assign is_packed = (op_e == AU_PADD) || (op_e == AU_PSUB);
    assign b_eff     = is_sub ? ~b : b;

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = ~rst & s1_adv;

    // Each lane's carry-in: the op's own cin at lane 0 and at every boundary in packed
    // modes, otherwise the carry rippling up from the lane below.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic          cin;
        logic          carry;
        logic          ov;
        logic [LW-1:0] sum;

        if (k == 0) begin : g_first
            assign cin = is_sub;
        end else begin : g_chain
            assign cin = is_packed ? is_sub : g_lane[k-1].carry;
        end

        au_lane #(.LW(LW)) u_lane (
            .a     (a[k*LW +: LW]),
            .b     (b_eff[k*LW +: LW]),
            .cin   (cin),
            .sum   (sum),
            .carry (carry),
            .ov    (ov)
        );

        assign lane_sum[k*LW +: LW] = sum;
        assign lane_ov[k]           = ov;
        assign lane_a_msb[k]        = a[k*LW + LW - 1];
    end

    assign s1_d.sum         = lane_sum;
    assign s1_d.ov          = lane_ov;
    assign s1_d.a_msb       = lane_a_msb;
    assign s1_d.packed_mode = is_packed;
    assign s1_d.cout        = g_lane[LANES-1].carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Full-width ops: the top lane's overflow, computed on the chained carry, is the word's overflow.
    always_comb begin
        sat_res = s1_q.sum;
        any_ov  = 1'b0;
        if (s1_q.packed_mode) begin
            any_ov = |s1_q.ov;
            for (int k = 0; k < LANES; k++) begin
                if (s1_q.ov[k]) begin
                    sat_res[k*LW +: LW] = s1_q.a_msb[k] ? LANE_MIN : LANE_MAX;
                end
            end
        end else begin
            any_ov = s1_q.ov[LANES-1];
            if (any_ov) begin
                sat_res = s1_q.a_msb[LANES-1] ? WORD_MIN : WORD_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            flag_n    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= sat_res;
                cout   <= s1_q.cout;
                flag_z <= ~|sat_res;
                flag_v <= any_ov;
                flag_n <= sat_res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_au_sat_pipe.sv
// Bench for au_sat_pipe (WIDTH=16, LANES=2): directed vectors, stall/reset sequences, random traffic.
module tb_au_sat_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        v;
        logic        n;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_taken = 0;
    exp_t q[$];

    au_sat_pipe #(.WIDTH(16), .LANES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: signed integer arithmetic per lane, clamped to the lane's range.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb);
        exp_t e;
        int lw, mask, half, ua, ub, sa, sb, r, res, vany, c;
        lw   = o[1] ? 8 : 16;
        mask = (1 << lw) - 1;
        half = 1 << (lw - 1);
        res  = 0;
        vany = 0;
        c    = 0;
        for (int k = 0; k < 16 / lw; k++) begin
            ua = (int'(va) >> (k * lw)) & mask;
            ub = (int'(vb) >> (k * lw)) & mask;
            sa = (ua >= half) ? ua - 2 * half : ua;
            sb = (ub >= half) ? ub - 2 * half : ub;
            r  = o[0] ? sa - sb : sa + sb;
            c  = o[0] ? ((ua - ub + (1 << lw)) >> lw) : ((ua + ub) >> lw);
            if (r > half - 1) begin
                r = half - 1;
                vany = 1;
            end else if (r < -half) begin
                r = -half;
                vany = 1;
            end
            res = res | ((r & mask) << (k * lw));
        end
        e.res  = res[15:0];
        e.cout = c[0];
        e.v    = vany[0];
        e.n    = res[15];
        e.z    = (res[15:0] == 16'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t dut_out();
        exp_t g;
        g = {result, cout, flag_v, flag_n, flag_z};
        return g;
    endfunction

    // One clock of traffic: drive, decide transfers just before the edge, score, then
    // confirm a stalled output held across the edge.
    task automatic step(input logic iv, input logic [1:0] o, input logic [15:0] va,
                        input logic [15:0] vb, input logic ordy, output logic acc);
        exp_t e;
        exp_t snap;
        logic hold;
        in_valid  = iv;
        op        = o;
        a         = va;
        b         = vb;
        out_ready = ordy;
        #3;
        acc  = in_valid & in_ready;
        hold = out_valid & ~out_ready;
        snap = dut_out();
        if (out_valid && out_ready) begin
            n_taken++;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_output: got 0x%0h, expected nothing outstanding", snap);
            end else begin
                e = q.pop_front();
                check("result_flags", 32'(snap), 32'(e));
            end
        end
        if (acc) q.push_back(model(o, va, vb));
        @(posedge clk);
        #1;
        if (hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(dut_out()), 32'(snap));
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic acc;
        step(1'b1, v.op, v.a, v.b, 1'b1, acc);
        check("accept", 32'(acc), 32'd1);
        check("latency_not_1", 32'(out_valid), 32'd0);
        step(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        check("latency_2_valid", 32'(out_valid), 32'd1);
        check("vector_out", 32'(dut_out()), 32'(v.exp));
        step(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [8];
        edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7F7F, 16'h8080, 16'h00FF};
        if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    initial begin
        vec_t  vecs [12];
        vec_t  ops4 [4];
        logic  acc;
        int    idx;
        int    taken0;

        //          op     a        b        res      c     v     n     z
        vecs[0]  = '{2'b00, 16'h7FFF, 16'h0001, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{2'b01, 16'h8000, 16'h0001, '{16'h8000, 1'b1, 1'b1, 1'b1, 1'b0}};
        vecs[2]  = '{2'b01, 16'h0000, 16'h8000, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[3]  = '{2'b00, 16'h0005, 16'hFFFB, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[4]  = '{2'b10, 16'h7F01, 16'h0101, '{16'h7F02, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[5]  = '{2'b11, 16'h8010, 16'h0120, '{16'h80F0, 1'b1, 1'b1, 1'b1, 1'b0}};
        vecs[6]  = '{2'b00, 16'h1234, 16'h1111, '{16'h2345, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{2'b11, 16'h0000, 16'h0000, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[8]  = '{2'b10, 16'h8080, 16'h8080, '{16'h8080, 1'b1, 1'b1, 1'b1, 1'b0}};
        vecs[9]  = '{2'b01, 16'h7FFF, 16'hFFFF, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[10] = '{2'b00, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[11] = '{2'b00, 16'h0000, 16'h0000, '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        a         = 16'h0;
        b         = 16'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_outputs", 32'(dut_out()), 32'd0);
        rst = 1'b0;
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);
        check("empty_drops_valid", 32'(out_valid), 32'd0);

        // Four ops offered back-to-back into a consumer that stalls for 5 cycles.
        ops4[0] = '{2'b00, 16'h0100, 16'h0023, '0};
        ops4[1] = '{2'b01, 16'h8000, 16'h0002, '0};
        ops4[2] = '{2'b10, 16'h7F7F, 16'h0101, '0};
        ops4[3] = '{2'b11, 16'h8000, 16'h0101, '0};
        idx = 0;
        taken0 = n_taken;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, ops4[idx].op, ops4[idx].a, ops4[idx].b, 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_accepted", 32'(idx), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 30 && (idx < 4 || q.size() != 0 || out_valid); c++) begin
            step(idx < 4, ops4[idx < 4 ? idx : 0].op, ops4[idx < 4 ? idx : 0].a,
                 ops4[idx < 4 ? idx : 0].b, 1'b1, acc);
            if (acc) idx++;
        end
        check("stall_all_out", 32'(n_taken - taken0), 32'd4);
        check("stall_queue_empty", 32'(q.size()), 32'd0);

        // Reset with two ops in flight discards them.
        step(1'b1, 2'b00, 16'h0001, 16'h0002, 1'b0, acc);
        step(1'b1, 2'b10, 16'h0003, 16'h0004, 1'b0, acc);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'(dut_out()), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        run_vec(vecs[5]);

        // Random traffic with random backpressure against the reference model.
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick(), pick(),
                 ($urandom_range(0, 2) != 0), acc);
        end
        for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++) begin
            step(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
